riscv_fetch: RTL and testbench



---
 rtl/riscv_constants.sv | 6 +
 rtl/riscv_defs.sv | 9 +
 rtl/riscv_fetch_fifo.sv | 62 ++++++
 rtl/riscv_fetch.sv | 120 ++++++++++++
 tb/tb_riscv_fetch.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_constants.sv
// rtl/riscv_constants.sv - core-wide default constants for kana-riscv
package riscv_constants;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/riscv_defs.sv
// rtl/riscv_defs.sv - shared pipeline types for kana-riscv
package riscv_defs;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// rtl/riscv_fetch_fifo.sv - in-order fetch buffer; flush wins over push and pop
module riscv_fetch_fifo
   import riscv_defs::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  fetch_entry_t  push_entry_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output fetch_entry_t  head_o,
   output logic [CW-1:0] occ_o
);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] occ_q, occ_d;
   logic          do_pop;

   assign do_pop = pop_i && (occ_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
         occ_d = occ_q + CW'(push_i) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (!rst && !flush_i && push_i) mem_q[wr_ptr_q] <= push_entry_i;
   end

   assign head_o = mem_q[rd_ptr_q];
   assign occ_o  = occ_q;

endmodule

// File: rtl/riscv_fetch.sv
// rtl/riscv_fetch.sv - instruction fetch stage; RISCV_FETCH_STALL_CNT_EN adds stall_cnt
module riscv_fetch
   import riscv_defs::*;
   import riscv_constants::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
`ifdef RISCV_FETCH_STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned CW1 = CW + 1;

   logic [31:0]   req_pc_q, req_pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic [CW-1:0] occ;
   logic [CW1-1:0] credit_used;
   logic [31:0]   redirect_pc_aligned;
   logic          pop, req_fire, rsp_keep;
   fetch_entry_t  head, push_entry;

   assign redirect_pc_aligned = redirect_pc & ~32'h3;
   assign inst_valid          = (occ != '0);
   assign pop                 = inst_valid && inst_ready;

   // Credit counts both buffered and in-flight words so every response has a slot.
   assign credit_used    = {1'b0, occ} + {1'b0, outstanding_q} - CW1'(pop);
   assign imem_req_valid = !rst && !redirect_valid && (credit_used < CW1'(FIFO_DEPTH));
   assign imem_req_addr  = req_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign rsp_keep       = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);

   always_comb begin
      req_pc_d      = req_pc_q;
      rsp_pc_d      = rsp_pc_q;
      drop_cnt_d    = drop_cnt_q;
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
         req_pc_d   = redirect_pc_aligned;
         rsp_pc_d   = redirect_pc_aligned;
         drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
      end else begin
         if (req_fire) req_pc_d = req_pc_q + 32'd4;
         if (rsp_keep) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
         end else if (imem_rsp_valid) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_pc_q      <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         req_pc_q      <= req_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   assign push_entry.pc   = rsp_pc_q;
   assign push_entry.inst = imem_rsp_data;

   riscv_fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (rsp_keep),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .flush_i      (redirect_valid),
      .head_o       (head),
      .occ_o        (occ)
   );

   assign inst    = head.inst;
   assign inst_pc = head.pc;

`ifdef RISCV_FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!inst_valid && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_fetch.sv
// tb/tb_riscv_fetch.sv - directed self-checking bench for riscv_fetch
module tb_riscv_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
`ifdef RISCV_FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   riscv_fetch #(
      .RESET_PC   (32'h0000_0100),
      .FIFO_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc)
`ifdef RISCV_FETCH_STALL_CNT_EN
      ,
      .stall_cnt      (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned due;
      logic [31:0] addr;
   } mreq_t;

   mreq_t       mq[$];
   int unsigned cyc;
   int unsigned lat;
   int          n_cmp;
   int          n_fail;
   logic        fire, popped;
   logic [31:0] fire_addr, pop_pc, pop_inst;
   logic [31:0] exp_pc;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
   endfunction

   // One clock: sample handshakes mid-cycle, then advance the memory model.
   task automatic step();
      mreq_t r;
      @(negedge clk);
      fire      = imem_req_valid && imem_req_ready;
      fire_addr = imem_req_addr;
      popped    = inst_valid && inst_ready;
      pop_pc    = inst_pc;
      pop_inst  = inst;
      @(posedge clk);
      #1;
      if (rst) begin
         mq.delete();
      end else if (fire === 1'b1) begin
         r.due  = cyc + lat;
         r.addr = fire_addr;
         mq.push_back(r);
      end
      cyc = cyc + 1;
      if (mq.size() != 0 && mq[0].due == cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_data(mq[0].addr);
         void'(mq.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      redirect_valid = 1'b0;
      lat            = 1;
      step();
      step();
      n_cmp++;
      if (imem_req_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_req_valid: got %b want 0", imem_req_valid);
      end
      n_cmp++;
      if (inst_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_inst_valid: got %b want 0", inst_valid);
      end
      n_cmp++;
      if (imem_req_addr !== 32'h100) begin
         n_fail++;
         $display("FAIL reset_req_addr: got %h want 00000100", imem_req_addr);
      end
`ifdef RISCV_FETCH_STALL_CNT_EN
      n_cmp++;
      if (stall_cnt !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
      end
`endif
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         n_cmp++;
         if (fire !== 1'b1 || fire_addr !== 32'h100 + 32'(4 * i)) begin
            n_fail++;
            $display("FAIL stream_req[%0d]: got fire=%b addr=%h want fire=1 addr=%h",
                     i, fire, fire_addr, 32'h100 + 32'(4 * i));
         end
         if (i >= 2) begin
            n_cmp++;
            if (popped !== 1'b1 || pop_pc !== 32'h100 + 32'(4 * (i - 2)) ||
                pop_inst !== mem_data(32'h100 + 32'(4 * (i - 2)))) begin
               n_fail++;
               $display("FAIL stream_pop[%0d]: got valid=%b pc=%h inst=%h want valid=1 pc=%h",
                        i, popped, pop_pc, pop_inst, 32'h100 + 32'(4 * (i - 2)));
            end
         end
      end
      exp_pc = 32'h120;
   endtask

   task automatic test_backpressure();
      int pops;
      inst_ready = 1'b0;
      for (int i = 0; i < 5; i++) step();
      n_cmp++;
      if (imem_req_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_req_valid: got %b want 0", imem_req_valid);
      end
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc) begin
         n_fail++;
         $display("FAIL bp_head: got valid=%b pc=%h want valid=1 pc=%h", inst_valid, inst_pc, exp_pc);
      end
      inst_ready = 1'b1;
      pops       = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (popped === 1'b1) begin
            pops++;
            n_cmp++;
            if (pop_pc !== exp_pc || pop_inst !== mem_data(exp_pc)) begin
               n_fail++;
               $display("FAIL bp_pop: got pc=%h inst=%h want pc=%h inst=%h",
                        pop_pc, pop_inst, exp_pc, mem_data(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
         end
      end
      n_cmp++;
      if (pops != 8) begin
         n_fail++;
         $display("FAIL bp_pop_count: got %0d want 8", pops);
      end
   endtask

   task automatic test_redirect_inflight();
      logic got;
      do_reset();
      lat            = 3;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      step();
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      step();
      redirect_valid = 1'b0;
      n_cmp++;
      if (imem_req_addr !== 32'h200) begin
         n_fail++;
         $display("FAIL redir_req_addr: got %h want 00000200", imem_req_addr);
      end
      n_cmp++;
      if (inst_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL redir_empty: got %b want 0", inst_valid);
      end
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         step();
         if (popped === 1'b1) begin
            got = 1'b1;
            n_cmp++;
            if (pop_pc !== 32'h200 || pop_inst !== mem_data(32'h200)) begin
               n_fail++;
               $display("FAIL redir_first_pop: got pc=%h inst=%h want pc=00000200 inst=%h",
                        pop_pc, pop_inst, mem_data(32'h200));
            end
         end
      end
      if (!got) begin
         n_cmp++;
         n_fail++;
         $display("FAIL redir_first_pop: got no instruction within 20 cycles want pc=00000200");
      end
   endtask

   task automatic test_redirect_rsp_pop();
      logic got;
      do_reset();
      lat            = 1;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      for (int i = 0; i < 4; i++) step();
      n_cmp++;
      if (inst_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rrp_pre_valid: got %b want 1", inst_valid);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      step();
      redirect_valid = 1'b0;
      n_cmp++;
      if (inst_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rrp_empty: got %b want 0", inst_valid);
      end
      step();
      n_cmp++;
      if (fire !== 1'b1 || fire_addr !== 32'h300) begin
         n_fail++;
         $display("FAIL rrp_req: got fire=%b addr=%h want fire=1 addr=00000300", fire, fire_addr);
      end
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         step();
         if (popped === 1'b1) begin
            got = 1'b1;
            n_cmp++;
            if (pop_pc !== 32'h300 || pop_inst !== mem_data(32'h300)) begin
               n_fail++;
               $display("FAIL rrp_first_pop: got pc=%h inst=%h want pc=00000300", pop_pc, pop_inst);
            end
         end
      end
      if (!got) begin
         n_cmp++;
         n_fail++;
         $display("FAIL rrp_first_pop: got no instruction within 10 cycles want pc=00000300");
      end
   endtask

   task automatic test_wrap();
      int          nf, np;
      logic [31:0] fa [2];
      logic [31:0] pa [2];
      logic [31:0] pi [2];
      for (int k = 0; k < 2; k++) begin
         fa[k] = 32'hDEAD_BEEF;
         pa[k] = 32'hDEAD_BEEF;
         pi[k] = 32'hDEAD_BEEF;
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
      step();
      redirect_valid = 1'b0;
      nf = 0;
      np = 0;
      for (int i = 0; i < 20 && (nf < 2 || np < 2); i++) begin
         step();
         if (fire === 1'b1 && nf < 2) begin
            fa[nf] = fire_addr;
            nf++;
         end
         if (popped === 1'b1 && np < 2) begin
            pa[np] = pop_pc;
            pi[np] = pop_inst;
            np++;
         end
      end
      n_cmp++;
      if (fa[0] !== 32'hFFFF_FFFC || fa[1] !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap_req: got %h,%h want fffffffc,00000000", fa[0], fa[1]);
      end
      n_cmp++;
      if (pa[0] !== 32'hFFFF_FFFC || pa[1] !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap_pop_pc: got %h,%h want fffffffc,00000000", pa[0], pa[1]);
      end
      n_cmp++;
      if (pi[0] !== mem_data(32'hFFFF_FFFC) || pi[1] !== mem_data(32'h0)) begin
         n_fail++;
         $display("FAIL wrap_pop_inst: got %h,%h want %h,%h",
                  pi[0], pi[1], mem_data(32'hFFFF_FFFC), mem_data(32'h0));
      end
   endtask

`ifdef RISCV_FETCH_STALL_CNT_EN
   task automatic test_stall_cnt();
      lat            = 1;
      imem_req_ready = 1'b0;
      inst_ready     = 1'b1;
      do_reset();
      for (int i = 0; i < 10; i++) step();
      imem_req_ready = 1'b1;
      step();
      step();
      n_cmp++;
      if (inst_valid !== 1'b1 || stall_cnt !== 32'd12) begin
         n_fail++;
         $display("FAIL stall_cnt_fill: got valid=%b cnt=%0d want valid=1 cnt=12", inst_valid, stall_cnt);
      end
      step();
      n_cmp++;
      if (stall_cnt !== 32'd12) begin
         n_fail++;
         $display("FAIL stall_cnt_hold: got %0d want 12", stall_cnt);
      end
   endtask
`endif

   initial begin
      n_cmp          = 0;
      n_fail         = 0;
      cyc            = 0;
      lat            = 1;
      rst            = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      inst_ready     = 1'b0;
      exp_pc         = 32'h0;
      test_reset();
      test_backpressure();
      test_redirect_inflight();
      test_redirect_rsp_pop();
      test_wrap();
`ifdef RISCV_FETCH_STALL_CNT_EN
      test_stall_cnt();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
